// File: rtl/fp_add_seq.sv
// fp_add_seq: sequential adder for the 1/4/8 floating-point format, start/ready/done handshake.
// Define FP_ADD_ROUND_EN to round half up on the final guard bit; undefined truncates.
`timescale 1ns/1ps
module fp_add_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [12:0] a,
   input  logic [12:0] b,
   output logic        ready,
   output logic        done,
   output logic [12:0] sum
);
   typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;
   state_t state, state_nxt;

   logic       big_s, sml_s, g;
   logic [3:0] big_e, sml_e;
   logic [7:0] big_f, sml_f;
   logic [8:0] r;

   logic [3:0] a_e, b_e, cap_big_e, cap_sml_e, cap_d;
   logic [7:0] cap_big_f, cap_sml_f;
   logic       cap_big_s, cap_sml_s, a_big;

   // A zero significand forces the exponent to zero before the magnitude sort.
   always_comb begin
      a_e   = (a[7:0] == 8'd0) ? 4'd0 : a[11:8];
      b_e   = (b[7:0] == 8'd0) ? 4'd0 : b[11:8];
      a_big = {a_e, a[7:0]} >= {b_e, b[7:0]};
      if (a_big) begin
         cap_big_s = a[12]; cap_big_e = a_e; cap_big_f = a[7:0];
         cap_sml_s = b[12]; cap_sml_e = b_e; cap_sml_f = b[7:0];
      end else begin
         cap_big_s = b[12]; cap_big_e = b_e; cap_big_f = b[7:0];
         cap_sml_s = a[12]; cap_sml_e = a_e; cap_sml_f = a[7:0];
      end
      cap_d = cap_big_e - cap_sml_e;
   end

   logic       accept, align_done, norm_done;
   logic [9:0] diff;

   assign accept     = start && ready;
   assign align_done = (sml_e == big_e) || (sml_f == 8'd0);
   assign diff       = {1'b0, big_f, 1'b0} - {1'b0, sml_f, g};
   assign norm_done  = (r == 9'd0) || r[8] || r[7] || (big_e <= 4'd1);

   logic [3:0] res_e;
   logic [7:0] res_f;
`ifdef FP_ADD_ROUND_EN
   logic [8:0] rnd;
   always_comb begin
      rnd   = {1'b0, r[7:0]} + {8'd0, g};
      res_e = big_e;
      res_f = rnd[7:0];
      if (rnd[8]) begin
         if (big_e == 4'hF) begin
            res_f = 8'hFF;
         end else begin
            res_f = 8'h80;
            res_e = big_e + 4'd1;
         end
      end
   end
`else
   assign res_e = big_e;
   assign res_f = r[7:0];
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = S_ALIGN;
         S_ALIGN: if (align_done) state_nxt = S_ADD;
         S_ADD:   state_nxt = S_NORM;
         S_NORM:  if (norm_done) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // ready stays low during the done pulse so a new start lands on the cycle after it.
   always_comb begin
      ready = (state == S_IDLE) && !done;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         big_s <= 1'b0; sml_s <= 1'b0; g <= 1'b0;
         big_e <= 4'd0; sml_e <= 4'd0;
         big_f <= 8'd0; sml_f <= 8'd0;
         r     <= 9'd0;
         done  <= 1'b0;
         sum   <= 13'h0000;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: if (accept) begin
               big_s <= cap_big_s; big_e <= cap_big_e; big_f <= cap_big_f;
               sml_s <= cap_sml_s; sml_e <= cap_sml_e;
               sml_f <= (cap_d > 4'd8) ? 8'd0 : cap_sml_f;
               g     <= 1'b0;
            end
            S_ALIGN: if (!align_done) begin
               sml_f <= sml_f >> 1;
               g     <= sml_f[0];
               sml_e <= sml_e + 4'd1;
            end
            S_ADD: begin
               if (big_s == sml_s) begin
                  r <= {1'b0, big_f} + {1'b0, sml_f};
               end else begin
                  r <= diff[9:1];
                  g <= diff[0];
               end
            end
            S_NORM: begin
               if (r == 9'd0) begin
                  r <= 9'd0; g <= 1'b0; big_s <= 1'b0; big_e <= 4'd0;
               end else if (r[8]) begin
                  if (big_e == 4'hF) begin
                     r <= 9'h0FF; g <= 1'b0;
                  end else begin
                     r     <= {1'b0, r[8:1]};
                     g     <= r[0];
                     big_e <= big_e + 4'd1;
                  end
               end else if (!r[7]) begin
                  if (big_e <= 4'd1) begin
                     r <= 9'd0; g <= 1'b0; big_s <= 1'b0; big_e <= 4'd0;
                  end else begin
                     r     <= {r[7:0], g};
                     g     <= 1'b0;
                     big_e <= big_e - 4'd1;
                  end
               end
            end
            S_DONE: begin
               sum  <= {big_s, res_e, res_f};
               done <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule
